// File: rtl/snake_pkg.sv
// Shared snake-game constants and the food controller state encoding.
package snake_pkg;

    localparam int FIELD_W = 64;
    localparam int FIELD_H = 32;
    localparam int X_W     = 7;
    localparam int Y_W     = 5;
    localparam int LEN_W   = 8;

    typedef enum logic [2:0] {
        REQ    = 3'd0,
        WAIT   = 3'd1,
        CHECK  = 3'd2,
        SCAN   = 3'd3,
        PLACED = 3'd4
    } food_state_e;

endpackage

// File: rtl/body_scan.sv
// Walks the snake-body RAM and compares every segment against a food candidate.
module body_scan (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [snake_pkg::LEN_W-1:0] len,
    input  logic [snake_pkg::X_W-1:0]   cand_x,
    input  logic [snake_pkg::Y_W-1:0]   cand_y,
    input  logic [snake_pkg::X_W-1:0]   body_x,
    input  logic [snake_pkg::Y_W-1:0]   body_y,
    output logic [snake_pkg::LEN_W-1:0] body_addr,
    output logic                        done,
    output logic                        hit
);
    import snake_pkg::*;

    logic             run_p0;
    logic [LEN_W-1:0] addr_p0;
    logic [LEN_W-1:0] len_p0;
    logic             at_last_p0;
    logic             vld_p1;
    logic             last_p1;
    logic             match_p1;

    assign at_last_p0 = (addr_p0 == len_p0 - LEN_W'(1));
    assign match_p1   = vld_p1 && (body_x == cand_x) && (body_y == cand_y);

    // p0: address issue; p1: RAM data returns and is compared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_p0  <= 1'b0;
            addr_p0 <= '0;
            len_p0  <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= run_p0 && !match_p1;
            last_p1 <= run_p0 && at_last_p0;
            if (start) begin
                run_p0  <= 1'b1;
                addr_p0 <= '0;
                len_p0  <= len;
            end else if (run_p0) begin
                // a hit aborts the walk early so the requester can retry at once
                if (match_p1 || at_last_p0) begin
                    run_p0  <= 1'b0;
                    addr_p0 <= '0;
                end else begin
                    addr_p0 <= addr_p0 + LEN_W'(1);
                end
            end
        end
    end

    assign body_addr = addr_p0;
    assign hit       = match_p1;
    assign done      = vld_p1 && last_p1;

endmodule

// File: rtl/food_ctrl.sv
// Requests food boxes, validates them against the field and snake body,
// publishes the placed food and tracks eating and score.
module food_ctrl #(
    parameter int FIELD_W   = snake_pkg::FIELD_W,
    parameter int FIELD_H   = snake_pkg::FIELD_H,
    parameter int GEN_LAT   = 2,
    parameter int MAX_RETRY = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        drive,
    input  logic [snake_pkg::X_W-1:0]   box_x,
    input  logic [snake_pkg::Y_W-1:0]   box_y,
    input  logic                        move_tick,
    input  logic [snake_pkg::X_W-1:0]   head_x,
    input  logic [snake_pkg::Y_W-1:0]   head_y,
    input  logic [snake_pkg::LEN_W-1:0] snake_len,
    output logic [snake_pkg::LEN_W-1:0] body_addr,
    input  logic [snake_pkg::X_W-1:0]   body_x,
    input  logic [snake_pkg::Y_W-1:0]   body_y,
    output logic [snake_pkg::X_W-1:0]   food_x,
    output logic [snake_pkg::Y_W-1:0]   food_y,
    output logic                        food_valid,
    output logic                        eaten,
    output logic [7:0]                  score,
    output logic                        gen_err
);
    import snake_pkg::*;

    localparam int WC_W = (GEN_LAT < 2) ? 1 : $clog2(GEN_LAT + 1);
    localparam int RT_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    food_state_e      state, state_nx;
    logic [WC_W-1:0]  wait_cnt;
    logic [RT_W-1:0]  retry_cnt;
    logic [X_W-1:0]   cand_x;
    logic [Y_W-1:0]   cand_y;
    logic [LEN_W-1:0] len_q;
    logic             capture, start_scan, accept, reject, eat;
    logic             out_of_field, retry_limit;
    logic             scan_done, scan_hit;

    assign out_of_field = (int'(cand_x) >= FIELD_W) || (int'(cand_y) >= FIELD_H);
    assign retry_limit  = (retry_cnt == RT_W'(MAX_RETRY - 1));

    body_scan u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_scan),
        .len       (len_q),
        .cand_x    (cand_x),
        .cand_y    (cand_y),
        .body_x    (body_x),
        .body_y    (body_y),
        .body_addr (body_addr),
        .done      (scan_done),
        .hit       (scan_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        capture    = 1'b0;
        start_scan = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        eat        = 1'b0;
        unique case (state)
            REQ:    state_nx = WAIT;
            WAIT: begin
                if (wait_cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                if (out_of_field) begin
                    reject = 1'b1;
                end else if (len_q == '0) begin
                    accept = 1'b1;
                end else begin
                    start_scan = 1'b1;
                    state_nx   = SCAN;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    reject = 1'b1;
                end else if (scan_done) begin
                    accept = 1'b1;
                end
            end
            PLACED: begin
                if (move_tick && head_x == food_x && head_y == food_y) begin
                    eat      = 1'b1;
                    state_nx = REQ;
                end
            end
            default: state_nx = REQ;
        endcase
        if (reject) state_nx = REQ;
        if (accept) state_nx = PLACED;
    end

    // drive is registered off REQ so it stays low while reset is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive      <= 1'b0;
            wait_cnt   <= '0;
            retry_cnt  <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            len_q      <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            eaten      <= 1'b0;
            score      <= '0;
            gen_err    <= 1'b0;
        end else begin
            drive   <= (state == REQ);
            eaten   <= eat;
            gen_err <= reject && retry_limit;
            if (state == REQ) begin
                wait_cnt <= WC_W'(GEN_LAT);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WC_W'(1);
            end
            if (capture) begin
                cand_x <= box_x;
                cand_y <= box_y;
                len_q  <= snake_len;
            end
            if (reject) begin
                retry_cnt <= retry_limit ? '0 : retry_cnt + RT_W'(1);
            end else if (accept) begin
                retry_cnt <= '0;
            end
            if (accept) begin
                food_x     <= cand_x;
                food_y     <= cand_y;
                food_valid <= 1'b1;
            end else if (eat) begin
                food_valid <= 1'b0;
            end
            if (eat) begin
                score <= sat_inc(score);
            end
        end
    end

endmodule

// File: tb/tb_food_ctrl.sv
// Scoreboard bench for food_ctrl with a random_box stand-in and a body RAM model.
module tb_food_ctrl;
    localparam int GEN_LAT = 2;

    typedef struct packed {logic [6:0] x; logic [4:0] y;} pos_t;
    typedef enum int {EV_PLACE = 0, EV_EAT = 1, EV_GERR = 2} ev_kind_e;
    typedef struct {ev_kind_e kind; int x; int y; int s; int aux;} exp_t;

    logic       clk, rst_n;
    logic       drive, move_tick, food_valid, eaten, gen_err;
    logic [6:0] box_x, head_x, body_x, food_x;
    logic [4:0] box_y, head_y, body_y, food_y;
    logic [7:0] snake_len, body_addr, score;

    exp_t exp_q[$];
    pos_t box_q[$];
    pos_t box_cur;
    int   n_cmp = 0, n_bad = 0, n_drive = 0, cyc_n = 0, last_drv = 0;
    logic fv_prev = 1'b0;
    logic [6:0] mem_x[256];
    logic [4:0] mem_y[256];

    food_ctrl #(.FIELD_W(64), .FIELD_H(32), .GEN_LAT(GEN_LAT), .MAX_RETRY(15)) dut (
        .clk(clk), .rst_n(rst_n), .drive(drive), .box_x(box_x), .box_y(box_y),
        .move_tick(move_tick), .head_x(head_x), .head_y(head_y), .snake_len(snake_len),
        .body_addr(body_addr), .body_x(body_x), .body_y(body_y), .food_x(food_x),
        .food_y(food_y), .food_valid(food_valid), .eaten(eaten), .score(score),
        .gen_err(gen_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        body_x <= mem_x[body_addr];
        body_y <= mem_y[body_addr];
    end

    // random_box stand-in: value valid only in the cycle it must be captured
    initial begin
        box_cur = '{x: 7'd127, y: 5'd31};
        box_x = 7'd127;
        box_y = 5'd31;
        forever begin
            @(posedge clk);
            if (rst_n && drive) begin
                if (box_q.size() != 0) box_cur = box_q.pop_front();
                repeat (GEN_LAT - 1) @(posedge clk);
                #1 box_x = box_cur.x; box_y = box_cur.y;
                @(posedge clk);
                #1 box_x = 7'd127; box_y = 5'd31;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic void expect_ev(ev_kind_e k, int x, int y, int s, int aux);
        exp_t e;
        e.kind = k; e.x = x; e.y = y; e.s = s; e.aux = aux;
        exp_q.push_back(e);
    endfunction

    task automatic take(input ev_kind_e k);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", int'(k), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", int'(k), int'(e.kind));
            case (k)
                EV_PLACE: begin
                    chk("food_x", food_x, e.x);
                    chk("food_y", food_y, e.y);
                    chk("place_score", score, e.s);
                    chk("place_latency", cyc_n - last_drv, e.aux);
                end
                EV_EAT: begin
                    chk("eat_score", score, e.s);
                    chk("eat_food_valid", food_valid, 0);
                end
                default: chk("gen_err_drives", n_drive, e.aux);
            endcase
        end
    endtask

    always @(negedge clk) begin
        cyc_n++;
        if (rst_n) begin
            if (drive) begin
                n_drive++;
                last_drv = cyc_n;
            end
            if (food_valid && !fv_prev) take(EV_PLACE);
            if (eaten) take(EV_EAT);
            if (gen_err) take(EV_GERR);
        end
        fv_prev = food_valid;
    end

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic tick(input int x, input int y);
        @(posedge clk);
        #1 head_x = 7'(x); head_y = 5'(y); move_tick = 1'b1;
        @(posedge clk);
        #1 move_tick = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_drive"}, drive, 0);
        chk({tag, "_food_x"}, food_x, 0);
        chk({tag, "_food_y"}, food_y, 0);
        chk({tag, "_food_valid"}, food_valid, 0);
        chk({tag, "_eaten"}, eaten, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_body_addr"}, body_addr, 0);
        chk({tag, "_gen_err"}, gen_err, 0);
    endtask

    initial begin
        int d0, s, s_n, n;
        rst_n = 1'b0; move_tick = 1'b0; head_x = '0; head_y = '0; snake_len = '0;
        for (int i = 0; i < 256; i++) begin
            mem_x[i] = 7'd1;
            mem_y[i] = 5'd1;
        end

        // first food after reset with an empty snake
        box_q.push_back('{x: 7'd10, y: 5'd5});
        repeat (3) @(posedge clk);
        #1 check_reset_vals("rst");
        rst_n = 1'b1;
        expect_ev(EV_PLACE, 10, 5, 0, GEN_LAT + 2);
        @(negedge clk) chk("drive_at_release", drive, 0);
        @(negedge clk) chk("drive_first", drive, 1);
        @(negedge clk) chk("drive_one_cycle", drive, 0);
        wait_drain(40, "first_food");

        // off-field candidate is rejected and re-requested
        box_q.push_back('{x: 7'd70, y: 5'd5});
        box_q.push_back('{x: 7'd20, y: 5'd8});
        d0 = n_drive;
        expect_ev(EV_EAT, 0, 0, 1, 0);
        expect_ev(EV_PLACE, 20, 8, 1, GEN_LAT + 2);
        tick(10, 5);
        wait_drain(60, "bounds");
        chk("bounds_drives", n_drive - d0, 2);

        // candidate on body segment 1 is rejected; second candidate needs a full scan
        mem_x[0] = 7'd20; mem_y[0] = 5'd8;
        mem_x[1] = 7'd19; mem_y[1] = 5'd8;
        mem_x[2] = 7'd18; mem_y[2] = 5'd8;
        snake_len = 8'd3;
        box_q.push_back('{x: 7'd19, y: 5'd8});
        box_q.push_back('{x: 7'd30, y: 5'd3});
        d0 = n_drive;
        expect_ev(EV_EAT, 0, 0, 2, 0);
        expect_ev(EV_PLACE, 30, 3, 2, GEN_LAT + 2 + 4);
        tick(20, 8);
        wait_drain(80, "body_hit");
        chk("body_hit_drives", n_drive - d0, 2);

        // head next to food: nothing happens
        tick(30, 4);
        repeat (6) @(negedge clk);
        chk("miss_food_valid", food_valid, 1);
        chk("miss_score", score, 2);

        // box stuck on an occupied cell: gen_err after 15 rejects
        box_q.push_back('{x: 7'd19, y: 5'd8});
        d0 = n_drive;
        expect_ev(EV_EAT, 0, 0, 3, 0);
        expect_ev(EV_GERR, 0, 0, 0, d0 + 15);
        tick(30, 3);
        wait_drain(400, "stuck");
        box_q.push_back('{x: 7'd40, y: 5'd10});
        expect_ev(EV_PLACE, 40, 10, 3, GEN_LAT + 2 + 4);
        wait_drain(80, "unstuck");

        // score climbs to 255 and holds there
        snake_len = 8'd0;
        box_q.push_back('{x: 7'd5, y: 5'd5});
        expect_ev(EV_EAT, 0, 0, 4, 0);
        expect_ev(EV_PLACE, 5, 5, 4, GEN_LAT + 2);
        tick(40, 10);
        wait_drain(40, "sat_start");
        s = 4;
        for (int i = 0; i < 253; i++) begin
            s_n = (s < 255) ? s + 1 : 255;
            expect_ev(EV_EAT, 0, 0, s_n, 0);
            expect_ev(EV_PLACE, 5, 5, s_n, GEN_LAT + 2);
            tick(5, 5);
            wait_drain(30, "sat_loop");
            s = s_n;
        end
        chk("score_saturated", score, 255);

        // reset in the middle of a long scan
        snake_len = 8'd200;
        box_q.push_back('{x: 7'd50, y: 5'd20});
        expect_ev(EV_EAT, 0, 0, 255, 0);
        tick(5, 5);
        wait_drain(20, "pre_reset_eat");
        n = 0;
        while (body_addr == 8'd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("scan_in_progress", body_addr != 8'd0, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid_rst");
        snake_len = 8'd0;
        box_q.push_back('{x: 7'd7, y: 5'd9});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_ev(EV_PLACE, 7, 9, 0, GEN_LAT + 2);
        wait_drain(40, "after_reset");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
